// File: rtl/serial_word_receiver_if.sv
// Link-side signal bundle for serial_word_receiver.
// master = link driver / downstream consumer, slave = the receiver itself.
interface serial_word_receiver_if #(
  parameter int WIDTH     = 18,
  parameter int CNT_WIDTH = 8
);
  logic                 input_data_1_bit;
  logic                 data_ctrl_input;
  logic [WIDTH-1:0]     received_word;
  logic                 word_valid;
  logic                 frame_error;
  logic [CNT_WIDTH-1:0] frame_count;
  logic                 busy;

  modport master (
    output input_data_1_bit, data_ctrl_input,
    input  received_word, word_valid, frame_error, frame_count, busy
  );

  modport slave (
    input  input_data_1_bit, data_ctrl_input,
    output received_word, word_valid, frame_error, frame_count, busy
  );
endinterface

// File: rtl/serial_word_receiver.sv
// Deserializes MSB-first frames delimited by the ctrl line into WIDTH-bit words,
// flags short/long frames and counts good frames.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ARM     | after reset; wait for ctrl low so a frame in flight is ignored
// IDLE    | between frames; first ctrl-high sample starts a frame
// SHIFT   | collecting payload bits
// OVERRUN | frame longer than WIDTH; discard until ctrl drops
module serial_word_receiver #(
  parameter int WIDTH     = 18,
  parameter int CNT_WIDTH = 8
) (
  input logic                   Ten_MHz_input_clock,
  input logic                   reset_n,
  serial_word_receiver_if.slave link
);
  localparam int BW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {ST_ARM, ST_IDLE, ST_SHIFT, ST_OVERRUN} state_t;

  state_t               state, state_nxt;
  logic                 d1, d2, c1, c2;
  logic [1:0]           fill_cnt;
  logic [WIDTH-1:0]     shreg, shreg_nxt;
  logic [BW-1:0]        bitcnt, bitcnt_nxt;
  logic [WIDTH-1:0]     word_q, word_nxt;
  logic [CNT_WIDTH-1:0] count_q, count_nxt;
  logic                 wv_q, wv_nxt, fe_q, fe_nxt, busy_q, busy_nxt;
  logic                 fill_done;
  logic                 bit_full;

  // c2 only reflects the real pin two edges after reset; until then ARM must
  // not treat the reset-value zeros as an inter-frame gap.
  assign fill_done = fill_cnt[1];
  assign bit_full  = (bitcnt == BW'(WIDTH));

  always_ff @(posedge Ten_MHz_input_clock) begin
    if (!reset_n) begin
      d1       <= 1'b0;
      d2       <= 1'b0;
      c1       <= 1'b0;
      c2       <= 1'b0;
      fill_cnt <= 2'd0;
      state    <= ST_ARM;
      shreg    <= '0;
      bitcnt   <= '0;
      word_q   <= '0;
      count_q  <= '0;
      wv_q     <= 1'b0;
      fe_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      d1       <= link.input_data_1_bit;
      d2       <= d1;
      c1       <= link.data_ctrl_input;
      c2       <= c1;
      if (!fill_done) fill_cnt <= fill_cnt + 2'd1;
      state    <= state_nxt;
      shreg    <= shreg_nxt;
      bitcnt   <= bitcnt_nxt;
      word_q   <= word_nxt;
      count_q  <= count_nxt;
      wv_q     <= wv_nxt;
      fe_q     <= fe_nxt;
      busy_q   <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    shreg_nxt  = shreg;
    bitcnt_nxt = bitcnt;
    word_nxt   = word_q;
    count_nxt  = count_q;
    wv_nxt     = 1'b0;
    fe_nxt     = 1'b0;
    case (state)
      ST_ARM: begin
        if (fill_done && !c2) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (c2) begin
          shreg_nxt  = {shreg[WIDTH-2:0], d2};
          bitcnt_nxt = BW'(1);
          state_nxt  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (c2) begin
          if (bit_full) begin
            state_nxt = ST_OVERRUN;
          end else begin
            shreg_nxt  = {shreg[WIDTH-2:0], d2};
            bitcnt_nxt = bitcnt + BW'(1);
          end
        end else begin
          if (bit_full) begin
            word_nxt  = shreg;
            wv_nxt    = 1'b1;
            count_nxt = count_q + CNT_WIDTH'(1);
          end else begin
            fe_nxt = 1'b1;
          end
          state_nxt = ST_IDLE;
        end
      end
      ST_OVERRUN: begin
        if (!c2) begin
          fe_nxt    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_ARM;
    endcase
    busy_nxt = (state_nxt == ST_SHIFT) || (state_nxt == ST_OVERRUN);
  end

  assign link.received_word = word_q;
  assign link.word_valid    = wv_q;
  assign link.frame_error   = fe_q;
  assign link.frame_count   = count_q;
  assign link.busy          = busy_q;
endmodule

// File: tb/tb_serial_word_receiver.sv
// Directed bench for serial_word_receiver: good/short/long frames, back-to-back,
// mid-frame reset and frame counter wrap.
module tb_serial_word_receiver;
  localparam int WIDTH     = 18;
  localparam int CNT_WIDTH = 8;

  logic clk;
  logic reset_n;
  int   cyc;
  int   n_cmp, n_err;

  serial_word_receiver_if #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) link ();

  serial_word_receiver #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .Ten_MHz_input_clock (clk),
    .reset_n             (reset_n),
    .link                (link.slave)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   wv_cnt, fe_cnt, both_cnt, tail_busy;
  int   last_wv_cyc, prev_wv_cyc, last_fe_cyc, busy_rise_cyc, busy_fall_cyc;
  logic busy_d, tail_watch;
  int   start_cyc, end_cyc;

  initial begin
    wv_cnt = 0; fe_cnt = 0; both_cnt = 0; tail_busy = 0;
    last_wv_cyc = -1; prev_wv_cyc = -1; last_fe_cyc = -1;
    busy_rise_cyc = -1; busy_fall_cyc = -1;
    busy_d = 1'b0; tail_watch = 1'b0;
  end

  always @(negedge clk) begin
    if (link.word_valid === 1'b1) begin
      wv_cnt++;
      prev_wv_cyc = last_wv_cyc;
      last_wv_cyc = cyc;
    end
    if (link.frame_error === 1'b1) begin
      fe_cnt++;
      last_fe_cyc = cyc;
    end
    if (link.word_valid === 1'b1 && link.frame_error === 1'b1) both_cnt++;
    if (link.busy === 1'b1 && !busy_d) busy_rise_cyc = cyc;
    if (link.busy === 1'b0 && busy_d) busy_fall_cyc = cyc;
    if (tail_watch && link.busy !== 1'b0) tail_busy++;
    busy_d = (link.busy === 1'b1);
  end

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      link.data_ctrl_input  = 1'b0;
      link.input_data_1_bit = 1'b0;
    end
  endtask

  // Sends w[n-1:0] MSB first with ctrl high, then exactly one ctrl-low cycle.
  task automatic send_bits(input logic [31:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk);
      if (i == n - 1) start_cyc = cyc;
      link.data_ctrl_input  = 1'b1;
      link.input_data_1_bit = w[i];
    end
    @(negedge clk);
    end_cyc = cyc;
    link.data_ctrl_input  = 1'b0;
    link.input_data_1_bit = 1'b0;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset_n = 1'b0;
    link.data_ctrl_input  = 1'b0;
    link.input_data_1_bit = 1'b0;
    repeat (n) @(negedge clk);
    reset_n = 1'b1;
  endtask

  int            wv0, fe0, e_cyc;
  logic [31:0]   w;

  initial begin
    n_cmp = 0; n_err = 0;
    reset_n = 1'b0;
    link.data_ctrl_input  = 1'b0;
    link.input_data_1_bit = 1'b0;
    repeat (3) @(negedge clk);
    chk_eq("rst_word",  32'(link.received_word), 32'h0);
    chk_eq("rst_wv",    32'(link.word_valid),    32'h0);
    chk_eq("rst_fe",    32'(link.frame_error),   32'h0);
    chk_eq("rst_count", 32'(link.frame_count),   32'h0);
    chk_eq("rst_busy",  32'(link.busy),          32'h0);
    reset_n = 1'b1;
    idle(5);

    // good frame
    wv0 = wv_cnt; fe0 = fe_cnt;
    send_bits(32'h2A5C3, 18);
    e_cyc = end_cyc;
    idle(5);
    chk_eq("good_wv_cnt",   32'(wv_cnt - wv0),        32'd1);
    chk_eq("good_wv_time",  32'(last_wv_cyc),         32'(e_cyc + 3));
    chk_eq("good_busy_up",  32'(busy_rise_cyc),       32'(start_cyc + 3));
    chk_eq("good_busy_dn",  32'(busy_fall_cyc),       32'(e_cyc + 3));
    chk_eq("good_word",     32'(link.received_word),  32'h2A5C3);
    chk_eq("good_count",    32'(link.frame_count),    32'd1);
    chk_eq("good_fe",       32'(fe_cnt - fe0),        32'd0);

    // short frame: 17 bits
    wv0 = wv_cnt; fe0 = fe_cnt;
    send_bits(32'h2A5C3 >> 1, 17);
    e_cyc = end_cyc;
    idle(5);
    chk_eq("short_fe_cnt",  32'(fe_cnt - fe0),        32'd1);
    chk_eq("short_fe_time", 32'(last_fe_cyc),         32'(e_cyc + 3));
    chk_eq("short_wv",      32'(wv_cnt - wv0),        32'd0);
    chk_eq("short_word",    32'(link.received_word),  32'h2A5C3);
    chk_eq("short_count",   32'(link.frame_count),    32'd1);

    // long frame: 20 bits
    wv0 = wv_cnt; fe0 = fe_cnt;
    send_bits(32'hABCDE, 20);
    e_cyc = end_cyc;
    idle(5);
    chk_eq("long_busy_up",  32'(busy_rise_cyc),       32'(start_cyc + 3));
    chk_eq("long_busy_dn",  32'(busy_fall_cyc),       32'(e_cyc + 3));
    chk_eq("long_fe_cnt",   32'(fe_cnt - fe0),        32'd1);
    chk_eq("long_fe_time",  32'(last_fe_cyc),         32'(e_cyc + 3));
    chk_eq("long_wv",       32'(wv_cnt - wv0),        32'd0);
    chk_eq("long_word",     32'(link.received_word),  32'h2A5C3);

    // back-to-back with a single gap cycle
    wv0 = wv_cnt; fe0 = fe_cnt;
    send_bits(32'h3FFFF, 18);
    send_bits(32'h00001, 18);
    idle(5);
    chk_eq("b2b_wv_cnt",    32'(wv_cnt - wv0),              32'd2);
    chk_eq("b2b_spacing",   32'(last_wv_cyc - prev_wv_cyc), 32'd19);
    chk_eq("b2b_word",      32'(link.received_word),        32'h00001);
    chk_eq("b2b_count",     32'(link.frame_count),          32'd3);
    chk_eq("b2b_fe",        32'(fe_cnt - fe0),              32'd0);

    // reset after 9 bits, ctrl stays high through the remaining 9
    w = 32'h1B2D4;
    for (int i = 17; i >= 9; i--) begin
      @(negedge clk);
      link.data_ctrl_input  = 1'b1;
      link.input_data_1_bit = w[i];
    end
    @(negedge clk);
    reset_n = 1'b0;
    link.input_data_1_bit = w[8];
    @(negedge clk);
    reset_n = 1'b1;
    tail_watch = 1'b1;
    wv0 = wv_cnt; fe0 = fe_cnt;
    chk_eq("mid_rst_busy",  32'(link.busy),           32'h0);
    chk_eq("mid_rst_word",  32'(link.received_word),  32'h0);
    chk_eq("mid_rst_count", 32'(link.frame_count),    32'h0);
    link.input_data_1_bit = w[7];
    for (int i = 6; i >= 0; i--) begin
      @(negedge clk);
      link.input_data_1_bit = w[i];
    end
    idle(6);
    tail_watch = 1'b0;
    chk_eq("tail_busy",     32'(tail_busy),           32'd0);
    chk_eq("tail_wv",       32'(wv_cnt - wv0),        32'd0);
    chk_eq("tail_fe",       32'(fe_cnt - fe0),        32'd0);
    send_bits(32'h15555, 18);
    idle(5);
    chk_eq("post_rst_word",  32'(link.received_word), 32'h15555);
    chk_eq("post_rst_count", 32'(link.frame_count),   32'd1);
    chk_eq("post_rst_wv",    32'(wv_cnt - wv0),       32'd1);

    // frame counter wrap
    do_reset(2);
    idle(5);
    wv0 = wv_cnt; fe0 = fe_cnt;
    for (int k = 1; k <= 256; k++) begin
      w = (32'(k) * 32'd1237 + 32'h155) & 32'h3FFFF;
      send_bits(w, 18);
      if (k == 255) begin
        idle(4);
        chk_eq("wrap_255", 32'(link.frame_count), 32'd255);
      end
    end
    idle(5);
    chk_eq("wrap_256",      32'(link.frame_count),    32'd0);
    chk_eq("wrap_word",     32'(link.received_word),  (32'd256 * 32'd1237 + 32'h155) & 32'h3FFFF);
    chk_eq("wrap_wv_cnt",   32'(wv_cnt - wv0),        32'd256);
    chk_eq("wrap_fe",       32'(fe_cnt - fe0),        32'd0);
    chk_eq("excl_strobes",  32'(both_cnt),            32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
